// File: rtl/token_printer.sv
// token_printer
// Turns the 16-bit lexer token stream back into printable ASCII bytes for
// debug dumps and host readback of the token buffer. Every token becomes one
// or more characters followed by a space; an EOF token becomes a newline and a
// NUL terminator, after which the block parks in DONE until reset.
//
// Ports:
//   CLK        clock, rising edge
//   RSTN       asynchronous active-low reset
//   I_VALID    token present on I_DATA
//   I_READY    token can be accepted (combinational, high only in IDLE)
//   I_DATA     token: [15:8] kind, [7:0] value
//   O_VALID    byte present on O_DATA (registered)
//   O_READY    downstream accepts the byte
//   O_DATA     ASCII byte (registered)
//   FOUND_EOF  sticky, set when the NUL terminator has been transferred
module token_printer #(
  parameter logic [7:0] TK_NUM = 8'h01,
  parameter logic [7:0] TK_SYM = 8'h02,
  parameter logic [7:0] TK_EOF = 8'hff
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [15:0] I_DATA,
  output logic        O_VALID,
  input  logic        O_READY,
  output logic [7:0]  O_DATA,
  output logic        FOUND_EOF
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] HUND = 4'd1;
  localparam logic [3:0] TENS = 4'd2;
  localparam logic [3:0] ONES = 4'd3;
  localparam logic [3:0] CHAR = 4'd4;
  localparam logic [3:0] SEP  = 4'd5;
  localparam logic [3:0] NL   = 4'd6;
  localparam logic [3:0] NUL  = 4'd7;
  localparam logic [3:0] DONE = 4'd8;

  logic [3:0] state_r;
  logic [3:0] hund_r;
  logic [3:0] tens_r;
  logic [3:0] ones_r;
  logic [7:0] char_r;
  logic       o_valid_r;
  logic [7:0] o_data_r;
  logic       found_eof_r;

  logic [3:0] next_state_s;
  logic       next_valid_s;
  logic [7:0] next_data_s;
  logic [7:0] next_char_s;
  logic       next_eof_s;

  logic       accept_s;
  logic       xfer_s;
  logic [7:0] kind_s;
  logic [7:0] value_s;
  logic [7:0] hund_full_s;
  logic [7:0] tens_full_s;
  logic [7:0] ones_full_s;
  logic [3:0] hund_s;
  logic [3:0] tens_s;
  logic [3:0] ones_s;

  // ASCII code of a decimal digit 0..9
  function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
    return {4'h3, digit};
  endfunction

  assign I_READY   = (state_r == IDLE);
  assign O_VALID   = o_valid_r;
  assign O_DATA    = o_data_r;
  assign FOUND_EOF = found_eof_r;

  assign accept_s = I_VALID && (state_r == IDLE);
  assign xfer_s   = o_valid_r && O_READY;

  assign kind_s  = I_DATA[15:8];
  assign value_s = I_DATA[7:0];

  // Decimal split of the numeric value; every result fits in 4 bits (0..9).
  assign hund_full_s = value_s / 8'd100;
  assign tens_full_s = (value_s / 8'd10) % 8'd10;
  assign ones_full_s = value_s % 8'd10;
  assign hund_s      = hund_full_s[3:0];
  assign tens_s      = tens_full_s[3:0];
  assign ones_s      = ones_full_s[3:0];

  // Next state and next output byte; the byte for a state is loaded on the
  // same edge that enters that state, so O_DATA always matches state_r.
  always_comb begin
    next_state_s = state_r;
    next_valid_s = o_valid_r;
    next_data_s  = o_data_r;
    next_char_s  = char_r;
    next_eof_s   = found_eof_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_valid_s = 1'b1;
          if (kind_s == TK_NUM && value_s != 8'hff) begin
            // Leading zeros are skipped, but ONES is always printed.
            if (hund_s != 4'd0) begin
              next_state_s = HUND;
              next_data_s  = digit_ascii(hund_s);
            end else if (tens_s != 4'd0) begin
              next_state_s = TENS;
              next_data_s  = digit_ascii(tens_s);
            end else begin
              next_state_s = ONES;
              next_data_s  = digit_ascii(ones_s);
            end
          end else if (kind_s == TK_SYM) begin
            next_state_s = CHAR;
            next_char_s  = value_s;
            next_data_s  = value_s;
          end else if (kind_s == TK_EOF) begin
            next_state_s = NL;
            next_data_s  = 8'h0a;
          end else begin
            // Invalid number or unknown kind prints '?'.
            next_state_s = CHAR;
            next_char_s  = 8'h3f;
            next_data_s  = 8'h3f;
          end
        end else begin
          next_valid_s = 1'b0;
        end
      end
      HUND: begin
        if (xfer_s) begin
          // Tens digit is always shown once hundreds were shown.
          next_state_s = TENS;
          next_data_s  = digit_ascii(tens_r);
        end else begin
          next_state_s = HUND;
        end
      end
      TENS: begin
        if (xfer_s) begin
          next_state_s = ONES;
          next_data_s  = digit_ascii(ones_r);
        end else begin
          next_state_s = TENS;
        end
      end
      ONES, CHAR: begin
        if (xfer_s) begin
          next_state_s = SEP;
          next_data_s  = 8'h20;
        end else begin
          next_state_s = state_r;
        end
      end
      SEP: begin
        if (xfer_s) begin
          next_state_s = IDLE;
          next_valid_s = 1'b0;
        end else begin
          next_state_s = SEP;
        end
      end
      NL: begin
        if (xfer_s) begin
          next_state_s = NUL;
          next_data_s  = 8'h00;
        end else begin
          next_state_s = NL;
        end
      end
      NUL: begin
        if (xfer_s) begin
          next_state_s = DONE;
          next_valid_s = 1'b0;
          next_eof_s   = 1'b1;
        end else begin
          next_state_s = NUL;
        end
      end
      DONE: begin
        next_state_s = DONE;
        next_valid_s = 1'b0;
      end
      default: begin
        next_state_s = IDLE;
        next_valid_s = 1'b0;
      end
    endcase
  end

  // Control, output and sticky EOF registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r     <= IDLE;
      o_valid_r   <= 1'b0;
      o_data_r    <= 8'h00;
      found_eof_r <= 1'b0;
      char_r      <= 8'h00;
    end else begin
      state_r     <= next_state_s;
      o_valid_r   <= next_valid_s;
      o_data_r    <= next_data_s;
      found_eof_r <= next_eof_s;
      char_r      <= next_char_s;
    end
  end

  // Digit registers captured when a token is accepted
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hund_r <= 4'd0;
      tens_r <= 4'd0;
      ones_r <= 4'd0;
    end else if (accept_s) begin
      hund_r <= hund_s;
      tens_r <= tens_s;
      ones_r <= ones_s;
    end
  end

endmodule

// File: tb/tb_token_printer.sv
module tb_token_printer;

  logic        CLK;
  logic        RSTN;
  logic        I_VALID;
  logic        I_READY;
  logic [15:0] I_DATA;
  logic        O_VALID;
  logic        O_READY;
  logic [7:0]  O_DATA;
  logic        FOUND_EOF;

  int check_count;
  int error_count;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  token_printer dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .I_VALID   (I_VALID),
    .I_READY   (I_READY),
    .I_DATA    (I_DATA),
    .O_VALID   (O_VALID),
    .O_READY   (O_READY),
    .O_DATA    (O_DATA),
    .FOUND_EOF (FOUND_EOF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record bytes that will transfer on the coming rising edge.
  always @(negedge CLK) begin
    if (RSTN && O_VALID && O_READY) got_q.push_back(O_DATA);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_token(input logic [15:0] tok);
    bit done;
    done = 1'b0;
    I_DATA  = tok;
    I_VALID = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (I_READY) done = 1'b1;
      step();
    end
    I_VALID = 1'b0;
    if (!done) check_value("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      if (I_READY && !O_VALID) idle = 1'b1;
      else step();
    end
    if (!idle) check_value("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_bytes(input string tag);
    check_value({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_value($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
  endtask

  initial begin
    int cnt;
    check_count = 0;
    error_count = 0;
    RSTN    = 1'b0;
    I_VALID = 1'b0;
    I_DATA  = 16'h0000;
    O_READY = 1'b1;
    step();
    check_value("rst_o_valid", O_VALID, 1'b0);
    check_value("rst_o_data", O_DATA, 8'h00);
    check_value("rst_eof", FOUND_EOF, 1'b0);
    check_value("rst_i_ready", I_READY, 1'b1);
    RSTN = 1'b1;
    step();

    // NUM 123: first byte right after acceptance, I_READY low for 4 cycles
    send_token(16'h017b);
    check_value("n123_first_valid", O_VALID, 1'b1);
    check_value("n123_first_data", O_DATA, 8'h31);
    cnt = 0;
    while (!I_READY && cnt < 50) begin
      step();
      cnt++;
    end
    check_value("n123_busy_cycles", cnt, 32'd4);
    check_value("n123_idle_valid", O_VALID, 1'b0);
    exp_q = {8'h31, 8'h32, 8'h33, 8'h20};
    compare_bytes("n123");

    // NUM 0 then NUM 105 back to back
    send_token(16'h0100);
    send_token(16'h0169);
    drain();
    exp_q = {8'h30, 8'h20, 8'h31, 8'h30, 8'h35, 8'h20};
    compare_bytes("n0_n105");

    // SYM '+' under backpressure
    O_READY = 1'b0;
    send_token(16'h022b);
    for (int i = 0; i < 3; i++) begin
      check_value($sformatf("bp_valid%0d", i), O_VALID, 1'b1);
      check_value($sformatf("bp_data%0d", i), O_DATA, 8'h2b);
      step();
    end
    check_value("bp_no_xfer", got_q.size(), 32'd0);
    O_READY = 1'b1;
    drain();
    exp_q = {8'h2b, 8'h20};
    compare_bytes("sym_plus");

    // Invalid number and unknown kind
    send_token(16'h01ff);
    send_token(16'h7712);
    drain();
    exp_q = {8'h3f, 8'h20, 8'h3f, 8'h20};
    compare_bytes("invalid");

    // Reset after '1' of NUM 123 has transferred
    send_token(16'h017b);
    step();
    check_value("mid_data", O_DATA, 8'h32);
    RSTN = 1'b0;
    #1;
    check_value("mid_rst_valid", O_VALID, 1'b0);
    check_value("mid_rst_data", O_DATA, 8'h00);
    check_value("mid_rst_ready", I_READY, 1'b1);
    step();
    RSTN = 1'b1;
    repeat (5) step();
    check_value("post_rst_valid", O_VALID, 1'b0);
    exp_q = {8'h31};
    compare_bytes("mid_rst");
    send_token(16'h0107);
    drain();
    exp_q = {8'h37, 8'h20};
    compare_bytes("after_rst");

    // EOF: newline, NUL, then terminal DONE
    send_token(16'hff00);
    check_value("eof_nl", O_DATA, 8'h0a);
    step();
    check_value("eof_nul", O_DATA, 8'h00);
    check_value("eof_not_yet", FOUND_EOF, 1'b0);
    step();
    check_value("eof_found", FOUND_EOF, 1'b1);
    check_value("eof_valid_low", O_VALID, 1'b0);
    I_DATA  = 16'h0105;
    I_VALID = 1'b1;
    repeat (5) step();
    check_value("done_ready", I_READY, 1'b0);
    check_value("done_valid", O_VALID, 1'b0);
    check_value("done_sticky", FOUND_EOF, 1'b1);
    I_VALID = 1'b0;
    exp_q = {8'h0a, 8'h00};
    compare_bytes("eof");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/token_printer.md
# token_printer

- Converts the 16-bit token stream produced by the lexer back into an ASCII byte stream. Used for debug dump and host readback of the token buffer.
- Each accepted token expands into one or more characters plus a trailing space separator.
- An EOF token emits a newline and a NUL terminator, then latches `FOUND_EOF`.
- Sits between the token FIFO (or lexer output) and the byte-wide UART/AXI-stream TX path; both sides use valid/ready.

## Interface

Parameters:
- `TK_NUM`, 8'h01: token kind of a numeric literal; `[7:0]` is the value (8'hff = invalid number).
- `TK_SYM`, 8'h02: token kind of a single-character symbol; `[7:0]` is its ASCII code.
- `TK_EOF`, 8'hff: end-of-file token kind; `[7:0]` ignored.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `I_VALID`  in  1  token present on `I_DATA`.
- `I_READY`  out  1  block can accept a token; combinational, high only in state IDLE.
- `I_DATA`  in  16  token: `[15:8]` kind, `[7:0]` value.
- `O_VALID`  out  1  byte present on `O_DATA`; registered.
- `O_READY`  in  1  downstream accepts byte.
- `O_DATA`  out  8  ASCII byte; registered.
- `FOUND_EOF`  out  1  sticky; set once the EOF terminator has been transferred.

## Operation

- A token is accepted on an edge where `I_VALID && I_READY`.
- A byte is transferred on an edge where `O_VALID && O_READY`.
- FSM states: IDLE, HUND, TENS, ONES, CHAR, SEP, NL, NUL, DONE.
- Accept in IDLE:
  - `TK_NUM` with value != 8'hff:
    - Digits h = v/100, t = (v/10)%10, o = v%10 are computed combinationally and stored in three 4-bit registers.
    - Next state is HUND if h != 0, else TENS if t != 0, else ONES. Leading zeros are suppressed; value 0 prints "0".
  - `TK_NUM` with value 8'hff, or an unknown kind: next state CHAR with char 8'h3f ('?').
  - `TK_SYM`: next state CHAR with char = `I_DATA[7:0]`.
  - `TK_EOF`: next state NL.
- Output bytes per state:
  - HUND, TENS, ONES: `O_DATA` = 8'h30 + digit.
  - CHAR: stored char.
  - SEP: 8'h20.
  - NL: 8'h0a.
  - NUL: 8'h00.
- The byte for the next state is loaded into `O_DATA` and `O_VALID` is set on the same edge as the state transition. Successive states advance only on a transfer edge.
- Chains after each transfer:
  - HUND -> TENS -> ONES -> SEP -> IDLE. A number with h != 0 always visits TENS, even if t == 0.
  - CHAR -> SEP -> IDLE.
  - NL -> NUL -> DONE.
- On entering IDLE or DONE, `O_VALID` is cleared.
- DONE:
  - `FOUND_EOF` = 1, `I_READY` = 0.
  - Terminal until reset; input tokens are not consumed.
- Digit arithmetic is 8-bit unsigned; digit registers are 4 bits, range 0..9.

## Timing

- Reset values: `O_VALID` 0, `O_DATA` 8'h00, `FOUND_EOF` 0, state IDLE, so `I_READY` = 1.
- Reset mid-operation discards the in-flight token and any partially emitted characters. No byte is emitted after reset release until a new token is accepted.
- Latency: token accepted at edge N, so the first byte is valid from the cycle after N.
- With `O_READY` held high, a token of k characters transfers bytes at edges N+1 .. N+k+1 (the separator is the last). `I_READY` is high again in the cycle after edge N+k+1, so throughput is k+2 cycles per token.
- Backpressure: while `O_VALID && !O_READY`, `O_DATA` and `O_VALID` are held stable and the state does not change. `O_VALID` never drops without a transfer.
- `I_READY` does not depend on `O_READY`; it depends only on the registered state.
- `FOUND_EOF` rises on the edge that transfers the NUL byte and is sticky until reset.
- `I_VALID` while not ready: the token is not consumed; the upstream must hold it.

## Test plan

- NUM 123 (16'h017b), `O_READY`=1 -> bytes 8'h31, 8'h32, 8'h33, 8'h20 on four consecutive cycles; `I_READY` low for 4 cycles.
- NUM 0 then NUM 105 back-to-back -> 8'h30, 8'h20, then 8'h31, 8'h30, 8'h35, 8'h20. The zero tens digit is kept and leading zeros are suppressed.
- SYM '+' (16'h022b) with `O_READY` low for 3 cycles after `O_VALID` rises -> `O_DATA` holds 8'h2b for those cycles, then 8'h2b, 8'h20 transfer.
- NUM 8'hff (16'h01ff) and unknown kind 16'h7712 -> each produces 8'h3f, 8'h20.
- EOF (16'hff00) -> bytes 8'h0a, 8'h00. `FOUND_EOF` rises at the NUL transfer edge; afterwards `I_READY`=0 with `I_VALID`=1 and no further bytes.
- `RSTN` pulsed low after the '1' of NUM 123 has been transferred -> outputs take their reset values immediately (asynchronously); no '2'/'3' is emitted after release; the next token is accepted normally.
